bitop_accel: RTL and testbench

- Memory-mapped bitwise-logic accelerator on the Ibex demo-system device bus.
- Generalised successor to the single-shot 16-bit AND peripheral, with:
  - Parametrised operand width.
  - Selectable operation.
  - LATENCY-stage compute pipeline.
  - DEPTH-entry result FIFO.
  - Sticky status flags.
  - Maskable, clearable interrupt.
- Software writes operands and pops results. Multiple operations may be in flight.

---
 rtl/bitop_accel_pkg.sv | 36 +++
 rtl/bitop_accel_if.sv | 20 ++
 rtl/bitop_fifo.sv | 46 ++++
 rtl/bitop_accel.sv | 168 ++++++++++++++++
 tb/tb_bitop_accel.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/bitop_accel_pkg.sv
// Shared types, register offsets and field positions for bitop_accel.
package bitop_accel_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_POPCNT = 3'd4
  } op_e;

  localparam logic [11:0] REG_CTRL    = 12'h000;
  localparam logic [11:0] REG_OPA     = 12'h004;
  localparam logic [11:0] REG_OPB     = 12'h008;
  localparam logic [11:0] REG_RESULT  = 12'h00C;
  localparam logic [11:0] REG_STATUS  = 12'h010;
  localparam logic [11:0] REG_IRQ_CLR = 12'h014;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_UNDERFLOW = 3;
  localparam int unsigned STAT_BUSY      = 4;
  localparam int unsigned STAT_CNT_LSB   = 8;

  localparam int unsigned CTRL_OP_LSB = 0;
  localparam int unsigned CTRL_IRQ_EN = 3;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/bitop_accel_if.sv
// Ibex demo-system device bus, grouped for bitop_accel.
interface bitop_accel_if;
  logic        device_req_i;
  logic [31:0] device_addr_i;
  logic        device_we_i;
  logic [3:0]  device_be_i;
  logic [31:0] device_wdata_i;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;

  modport master (
    output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    input  device_rvalid_o, device_rdata_o
  );

  modport slave (
    input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    output device_rvalid_o, device_rdata_o
  );
endinterface

// File: rtl/bitop_fifo.sv
// Generic synchronous FIFO with combinational head read.
module bitop_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata,
  output logic [$clog2(Depth):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  r_mem [Depth];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [PtrW:0]     r_count;
  logic              w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PtrW+1)'(Depth));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/bitop_accel.sv
// Memory-mapped bitwise-logic accelerator: register decode, compute pipeline, result FIFO.
// Optional popcount op guarded by BITOP_ACCEL_POPCOUNT_EN.
module bitop_accel
  import bitop_accel_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned Latency   = 2
) (
  input  logic             clk,
  input  logic             rst_ni,
  bitop_accel_if.slave     bus,
  output logic             irq_o
);
  localparam logic [31:0] Mask = 32'hFFFF_FFFF >> (32 - DataWidth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [3:0]           r_ctrl;
  logic [DataWidth-1:0] r_opa;
  logic                 r_irq_pend, r_ovf, r_udf, r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_vld [Latency];
  logic [31:0]          r_dat [Latency];

  logic [11:0]          w_addr;
  logic                 w_rd, w_wr, w_pop, w_udf_set, w_issue, w_accept, w_push, w_busy;
  logic [31:0]          w_a, w_b, w_and, w_stage_in, w_res, w_credits, w_rmux, w_status;
  logic [DataWidth-1:0] w_fifo_rdata;
  logic [CntW-1:0]      w_count;
  logic                 w_full, w_empty, w_unused;

  assign w_unused = ^{bus.device_be_i, bus.device_addr_i[31:12], bus.device_wdata_i};

  assign w_addr    = bus.device_addr_i[11:0];
  assign w_rd      = bus.device_req_i && !bus.device_we_i;
  assign w_wr      = bus.device_req_i && bus.device_we_i;
  assign w_pop     = w_rd && (w_addr == REG_RESULT) && !w_empty;
  assign w_udf_set = w_rd && (w_addr == REG_RESULT) && w_empty;
  assign w_issue   = w_wr && (w_addr == REG_OPB);
  // Credits are taken before any same-cycle pop, so a full system drops the write.
  assign w_accept  = w_issue && (w_credits < 32'(Depth));
  assign w_push    = r_vld[Latency-1];

  always_comb begin
    w_credits = 32'(w_count);
    w_busy    = 1'b0;
    for (int unsigned i = 0; i < Latency; i++) begin
      w_credits = w_credits + 32'(r_vld[i]);
      w_busy    = w_busy | r_vld[i];
    end
  end

  assign w_a   = 32'(r_opa);
  assign w_b   = bus.device_wdata_i & Mask;
  assign w_and = w_a & w_b;

  always_comb begin
    w_stage_in = '0;
    case (op_e'(r_ctrl[CTRL_OP_LSB +: 3]))
      OP_AND:  w_stage_in = w_and;
      OP_OR:   w_stage_in = w_a | w_b;
      OP_XOR:  w_stage_in = w_a ^ w_b;
      OP_NAND: w_stage_in = ~w_and & Mask;
`ifdef BITOP_ACCEL_POPCOUNT_EN
      // First tree level: per-byte counts packed as nibbles, summed at the last stage.
      OP_POPCNT: w_stage_in = {16'b0, popcnt8(w_and[31:24]), popcnt8(w_and[23:16]),
                               popcnt8(w_and[15:8]), popcnt8(w_and[7:0])};
`endif
      default: w_stage_in = '0;
    endcase
  end

`ifdef BITOP_ACCEL_POPCOUNT_EN
  logic r_pop [Latency];
  logic [5:0] w_pc_sum;

  assign w_pc_sum = 6'(r_dat[Latency-1][3:0])   + 6'(r_dat[Latency-1][7:4])
                  + 6'(r_dat[Latency-1][11:8])  + 6'(r_dat[Latency-1][15:12]);
  assign w_res    = r_pop[Latency-1] ? (32'(w_pc_sum) & Mask) : r_dat[Latency-1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Latency; i++) r_pop[i] <= 1'b0;
    end else begin
      r_pop[0] <= (op_e'(r_ctrl[CTRL_OP_LSB +: 3]) == OP_POPCNT);
      for (int unsigned i = 1; i < Latency; i++) r_pop[i] <= r_pop[i-1];
    end
  end
`else
  assign w_res = r_dat[Latency-1];
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Latency; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      r_dat[0] <= w_stage_in;
      for (int unsigned i = 1; i < Latency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  bitop_fifo #(.Width(DataWidth), .Depth(Depth)) u_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_res[DataWidth-1:0]),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status                         = '0;
    w_status[STAT_EMPTY]             = w_empty;
    w_status[STAT_FULL]              = w_full;
    w_status[STAT_OVERFLOW]          = r_ovf;
    w_status[STAT_UNDERFLOW]         = r_udf;
    w_status[STAT_BUSY]              = w_busy;
    w_status[STAT_CNT_LSB +: 8]      = 8'(w_count);
  end

  always_comb begin
    w_rmux = '0;
    case (w_addr)
      REG_CTRL:   w_rmux = 32'(r_ctrl);
      REG_OPA:    w_rmux = 32'(r_opa);
      REG_RESULT: w_rmux = w_empty ? '0 : 32'(w_fifo_rdata);
      REG_STATUS: w_rmux = w_status;
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl     <= '0;
      r_opa      <= '0;
      r_irq_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid <= bus.device_req_i;
      r_rdata  <= w_rd ? w_rmux : '0;
      if (w_wr && w_addr == REG_CTRL) r_ctrl <= bus.device_wdata_i[3:0];
      if (w_wr && w_addr == REG_OPA)  r_opa  <= bus.device_wdata_i[DataWidth-1:0];
      if (w_push) r_irq_pend <= 1'b1;
      else if (w_wr && w_addr == REG_IRQ_CLR && bus.device_wdata_i[0]) r_irq_pend <= 1'b0;
      if (w_issue && !w_accept) r_ovf <= 1'b1;
      else if (w_wr && w_addr == REG_IRQ_CLR && bus.device_wdata_i[1]) r_ovf <= 1'b0;
      if (w_udf_set) r_udf <= 1'b1;
      else if (w_wr && w_addr == REG_IRQ_CLR && bus.device_wdata_i[2]) r_udf <= 1'b0;
    end
  end

  assign bus.device_rvalid_o = r_rvalid;
  assign bus.device_rdata_o  = r_rdata;
  assign irq_o               = r_irq_pend & r_ctrl[CTRL_IRQ_EN];
endmodule

// File: tb/tb_bitop_accel.sv
// Directed bench for bitop_accel: a 32-bit and an 8-bit instance on one clock/reset.
module tb_bitop_accel;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic irq32, irq8;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bitop_accel_if bus32 ();
  bitop_accel_if bus8 ();

  bitop_accel u_dut32 (.clk(clk), .rst_ni(rst_ni), .bus(bus32), .irq_o(irq32));
  bitop_accel #(.DataWidth(8)) u_dut8 (.clk(clk), .rst_ni(rst_ni), .bus(bus8), .irq_o(irq8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge; returns one falling edge later with the response sampled.
  task automatic acc(input bit sel, input logic [11:0] a, input bit we,
                     input logic [31:0] wd, output logic [31:0] rd);
    if (!sel) begin
      bus32.device_req_i = 1'b1; bus32.device_addr_i = {20'h0, a};
      bus32.device_we_i = we; bus32.device_wdata_i = wd; bus32.device_be_i = 4'hF;
    end else begin
      bus8.device_req_i = 1'b1; bus8.device_addr_i = {20'hABCDE, a};
      bus8.device_we_i = we; bus8.device_wdata_i = wd; bus8.device_be_i = 4'h0;
    end
    @(negedge clk);
    if (!sel) begin
      chk("rvalid32", 32'(bus32.device_rvalid_o), 32'd1);
      rd = bus32.device_rdata_o;
      bus32.device_req_i = 1'b0;
    end else begin
      chk("rvalid8", 32'(bus8.device_rvalid_o), 32'd1);
      rd = bus8.device_rdata_o;
      bus8.device_req_i = 1'b0;
    end
  endtask

  logic [31:0] rd;

  initial begin
    bus32.device_req_i = 0; bus32.device_addr_i = '0; bus32.device_we_i = 0;
    bus32.device_be_i = '0; bus32.device_wdata_i = '0;
    bus8.device_req_i = 0; bus8.device_addr_i = '0; bus8.device_we_i = 0;
    bus8.device_be_i = '0; bus8.device_wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(bus32.device_rvalid_o), 32'd0);
    chk("rst_rdata", bus32.device_rdata_o, 32'd0);
    chk("rst_irq", 32'(irq32), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    acc(0, 12'h010, 0, 0, rd); chk("status_reset", rd, 32'h1);
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(bus32.device_rvalid_o), 32'd0);
    acc(0, 12'h000, 0, 0, rd); chk("ctrl_reset", rd, 32'h0);

    // AND
    acc(0, 12'h000, 1, 32'h0, rd);
    acc(0, 12'h004, 1, 32'hF0F0_00FF, rd);
    acc(0, 12'h008, 1, 32'h0FF0_FF0F, rd); chk("write_rdata0", rd, 32'h0);
    repeat (2) @(negedge clk);
    acc(0, 12'h010, 0, 0, rd); chk("status_cnt1", rd, 32'h0000_0100);
    chk("irq_masked", 32'(irq32), 32'd0);
    acc(0, 12'h00C, 0, 0, rd); chk("and_result", rd, 32'h00F0_000F);
    acc(0, 12'h010, 0, 0, rd); chk("status_empty", rd, 32'h1);

    // OR with irq, fill and overflow
    acc(0, 12'h000, 1, 32'h9, rd);
    acc(0, 12'h004, 1, 32'h10, rd);
    acc(0, 12'h008, 1, 32'h1, rd);
    acc(0, 12'h008, 1, 32'h2, rd);
    acc(0, 12'h008, 1, 32'h4, rd);
    acc(0, 12'h008, 1, 32'h8, rd);
    acc(0, 12'h008, 1, 32'hFF, rd);
    repeat (3) @(negedge clk);
    acc(0, 12'h010, 0, 0, rd); chk("status_full_ovf", rd, 32'h0000_0406);
    chk("irq_set", 32'(irq32), 32'd1);
    acc(0, 12'h00C, 0, 0, rd); chk("pop0", rd, 32'h11);
    acc(0, 12'h00C, 0, 0, rd); chk("pop1", rd, 32'h12);
    acc(0, 12'h00C, 0, 0, rd); chk("pop2", rd, 32'h14);
    acc(0, 12'h00C, 0, 0, rd); chk("pop3", rd, 32'h18);
    chk("irq_held", 32'(irq32), 32'd1);
    acc(0, 12'h014, 1, 32'h3, rd);
    chk("irq_cleared", 32'(irq32), 32'd0);
    acc(0, 12'h010, 0, 0, rd); chk("status_ovf_clr", rd, 32'h1);

    // Underflow
    acc(0, 12'h00C, 0, 0, rd); chk("underflow_rd", rd, 32'h0);
    acc(0, 12'h010, 0, 0, rd); chk("status_udf", rd, 32'h9);
    acc(0, 12'h014, 1, 32'h4, rd);
    acc(0, 12'h010, 0, 0, rd); chk("status_udf_clr", rd, 32'h1);
    acc(0, 12'h020, 0, 0, rd); chk("unmapped_rd", rd, 32'h0);
    acc(0, 12'h008, 0, 0, rd); chk("opb_rd", rd, 32'h0);

    // 8-bit instance: NAND masked, op 5
    acc(1, 12'h000, 1, 32'h3, rd);
    acc(1, 12'h004, 1, 32'hFFFF_FFAA, rd);
    acc(1, 12'h004, 0, 0, rd); chk("opa8_masked", rd, 32'hAA);
    acc(1, 12'h008, 1, 32'h0F, rd);
    repeat (2) @(negedge clk);
    acc(1, 12'h00C, 0, 0, rd); chk("nand8", rd, 32'hF5);
    acc(1, 12'h000, 1, 32'h5, rd);
    acc(1, 12'h008, 1, 32'hFF, rd);
    repeat (2) @(negedge clk);
    acc(1, 12'h010, 0, 0, rd); chk("op5_cnt1", rd, 32'h100);
    acc(1, 12'h00C, 0, 0, rd); chk("op5_zero", rd, 32'h0);

    // Popcount op
    acc(0, 12'h000, 1, 32'h4, rd);
    acc(0, 12'h004, 1, 32'hFFFF_FFFF, rd);
    acc(0, 12'h008, 1, 32'h8000_0007, rd);
    repeat (2) @(negedge clk);
`ifdef BITOP_ACCEL_POPCOUNT_EN
    acc(0, 12'h00C, 0, 0, rd); chk("popcnt", rd, 32'h4);
`else
    acc(0, 12'h00C, 0, 0, rd); chk("popcnt_off", rd, 32'h0);
`endif

    // Reset with two ops in flight
    acc(0, 12'h000, 1, 32'h8, rd);
    acc(0, 12'h008, 1, 32'h1, rd);
    acc(0, 12'h008, 1, 32'h2, rd);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    acc(0, 12'h010, 0, 0, rd); chk("status_after_rst", rd, 32'h1);
    chk("irq_after_rst", 32'(irq32), 32'd0);
    acc(0, 12'h004, 0, 0, rd); chk("opa_after_rst", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
